// File: rtl/common.sv
// Shared pipeline-control types: hazard FSM states, forwarding selects and
// the load-use hazard detection function used by the hazard control unit.
package common;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        EX_WAIT    = 2'd2,
        FLUSH      = 2'd3
    } hazard_state_type;

    // Operand-forwarding selects belong to the forwarding unit; kept here so
    // both units share one definition.
    typedef enum logic [1:0] {
        FWD_NONE   = 2'd0,
        FWD_EX_MEM = 2'd1,
        FWD_MEM_WB = 2'd2
    } forward_type;

    localparam int REG_ADDR_W = 5;

    // A load in EX whose destination is a register actually read in ID.
    // x0 is hardwired zero, so a load targeting it never creates a hazard.
    function automatic logic detect_load_use(
        input logic                  mem_read,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic                  rs1_used,
        input logic [REG_ADDR_W-1:0] rs2,
        input logic                  rs2_used
    );
        logic rs1_hit;
        logic rs2_hit;
        rs1_hit = rs1_used && (rd == rs1);
        rs2_hit = rs2_used && (rd == rs2);
        return mem_read && (rd != '0) && (rs1_hit || rs2_hit);
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module perf_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: stalls on load-use and multi-cycle EX, flushes on
// taken branches, and counts stall cycles and flush events.
module hazard_control_unit
    import common::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic                  mem_read_ex,
    input  logic                  ex_busy,
    input  logic                  branch_taken_ex,
    input  logic                  perf_clear,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  id_ex_write_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output hazard_state_type      hazard_state,
    output logic [COUNT_W-1:0]    stall_cycles,
    output logic [COUNT_W-1:0]    flush_events
);

    hazard_state_type state_q;
    hazard_state_type state_d;

    logic load_use;
    logic load_use_eff;

    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic if_id_fl;
    logic id_ex_fl;

    assign load_use = detect_load_use(mem_read_ex, rd_ex, rs1_id, rs1_used,
                                      rs2_id, rs2_used);

    // The bubble inserted in LOAD_STALL has already moved the load on, so the
    // still-visible match must not stall a second time.
    assign load_use_eff = load_use && (state_q != LOAD_STALL);

    always_comb begin
        state_d  = RUN;
        pc_we    = 1'b1;
        if_id_we = 1'b1;
        id_ex_we = 1'b1;
        if_id_fl = 1'b0;
        id_ex_fl = 1'b0;
        if (branch_taken_ex) begin
            if_id_fl = 1'b1;
            id_ex_fl = 1'b1;
            state_d  = FLUSH;
        end else if (ex_busy) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            id_ex_we = 1'b0;
            state_d  = EX_WAIT;
        end else if (load_use_eff) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            id_ex_fl = 1'b1;
            state_d  = LOAD_STALL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Hold the whole pipeline frozen and unflushed while reset is asserted.
    assign pc_write_en    = reset_n && pc_we;
    assign if_id_write_en = reset_n && if_id_we;
    assign id_ex_write_en = reset_n && id_ex_we;
    assign if_id_flush    = reset_n && if_id_fl;
    assign id_ex_flush    = reset_n && id_ex_fl;
    assign hazard_state   = state_q;

    perf_counter #(
        .WIDTH (COUNT_W)
    ) u_stall_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (!pc_write_en),
        .clear   (perf_clear),
        .count   (stall_cycles)
    );

    perf_counter #(
        .WIDTH (COUNT_W)
    ) u_flush_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (branch_taken_ex),
        .clear   (perf_clear),
        .count   (flush_events)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: a 16-bit and a 4-bit instance share stimulus; the narrow one
// exposes counter saturation within a few cycles.
module tb_hazard_control_unit;
    import common::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
    logic       rs1_used = 1'b0, rs2_used = 1'b0, mem_read_ex = 1'b0;
    logic       ex_busy = 1'b0, branch_taken_ex = 1'b0, perf_clear = 1'b0;

    logic             pc_we, ifid_we, idex_we, ifid_fl, idex_fl;
    hazard_state_type st;
    logic [15:0]      stalls, flushes;

    logic             s_pc_we, s_ifid_we, s_idex_we, s_ifid_fl, s_idex_fl;
    hazard_state_type s_st;
    logic [3:0]       s_stalls, s_flushes;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.COUNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .ex_busy(ex_busy),
        .branch_taken_ex(branch_taken_ex), .perf_clear(perf_clear),
        .pc_write_en(pc_we), .if_id_write_en(ifid_we), .id_ex_write_en(idex_we),
        .if_id_flush(ifid_fl), .id_ex_flush(idex_fl), .hazard_state(st),
        .stall_cycles(stalls), .flush_events(flushes)
    );

    hazard_control_unit #(.COUNT_W(4)) dut_small (
        .clk(clk), .reset_n(reset_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .ex_busy(ex_busy),
        .branch_taken_ex(branch_taken_ex), .perf_clear(perf_clear),
        .pc_write_en(s_pc_we), .if_id_write_en(s_ifid_we), .id_ex_write_en(s_idex_we),
        .if_id_flush(s_ifid_fl), .id_ex_flush(s_idex_fl), .hazard_state(s_st),
        .stall_cycles(s_stalls), .flush_events(s_flushes)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed view of the five control outputs: {pc, ifid_we, idex_we, ifid_fl, idex_fl}
    function automatic logic [4:0] ctl();
        return {pc_we, ifid_we, idex_we, ifid_fl, idex_fl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_read_ex = 0; rd_ex = 0; rs1_id = 0; rs2_id = 0;
        rs1_used = 0; rs2_used = 0; ex_busy = 0; branch_taken_ex = 0; perf_clear = 0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                            input logic [4:0] r2, input logic u2);
        mem_read_ex = 1; rd_ex = rd; rs1_id = r1; rs1_used = u1; rs2_id = r2; rs2_used = u2;
    endtask

    initial begin
        // Reset state
        #2;
        chk("reset_ctl", {27'd0, ctl()}, 32'h00);
        chk("reset_state", {30'd0, st}, {30'd0, RUN});
        chk("reset_stalls", {16'd0, stalls}, 32'd0);
        chk("reset_flushes", {16'd0, flushes}, 32'd0);
        @(posedge clk); #1 reset_n = 1;
        #1;
        chk("idle_ctl", {27'd0, ctl()}, 32'b11100);
        tick();
        chk("idle_stalls", {16'd0, stalls}, 32'd0);

        // Load-use on rs1: one-cycle stall with bubble
        set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        chk("lu1_ctl", {27'd0, ctl()}, 32'b00101);
        tick();
        chk("lu1_state", {30'd0, st}, {30'd0, LOAD_STALL});
        chk("lu1_c2_ctl", {27'd0, ctl()}, 32'b11100);
        chk("lu1_stalls", {16'd0, stalls}, 32'd1);
        idle();
        tick();
        chk("lu1_back_run", {30'd0, st}, {30'd0, RUN});

        // No hazard: rd_ex is x0
        set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        #1;
        chk("x0_ctl", {27'd0, ctl()}, 32'b11100);
        tick();
        chk("x0_state", {30'd0, st}, {30'd0, RUN});

        // No hazard: rs2 matches but is not read
        set_load(5'd5, 5'd3, 1'b1, 5'd5, 1'b0);
        #1;
        chk("rs2unused_ctl", {27'd0, ctl()}, 32'b11100);
        tick();
        chk("rs2unused_state", {30'd0, st}, {30'd0, RUN});
        chk("nohaz_stalls", {16'd0, stalls}, 32'd1);

        // Hazard through rs2 when it is read
        set_load(5'd5, 5'd3, 1'b1, 5'd5, 1'b1);
        #1;
        chk("rs2used_ctl", {27'd0, ctl()}, 32'b00101);
        tick();
        chk("rs2used_state", {30'd0, st}, {30'd0, LOAD_STALL});
        idle();
        tick();

        // ex_busy for 4 cycles with load_use pending, then the load stall
        set_load(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
        ex_busy = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("busy_ctl_%0d", i), {27'd0, ctl()}, 32'b00000);
            tick();
            chk($sformatf("busy_state_%0d", i), {30'd0, st}, {30'd0, EX_WAIT});
        end
        ex_busy = 0;
        #1;
        chk("post_busy_lu_ctl", {27'd0, ctl()}, 32'b00101);
        tick();
        chk("post_busy_state", {30'd0, st}, {30'd0, LOAD_STALL});
        chk("busy_stalls", {16'd0, stalls}, 32'd7);
        chk("lstall_ignore_ctl", {27'd0, ctl()}, 32'b11100);
        idle();
        tick();

        // Branch outranks load_use
        set_load(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        branch_taken_ex = 1;
        #1;
        chk("br_ctl", {27'd0, ctl()}, 32'b11111);
        tick();
        chk("br_state", {30'd0, st}, {30'd0, FLUSH});
        chk("br_flushes", {16'd0, flushes}, 32'd1);
        chk("br_stalls_unchanged", {16'd0, stalls}, 32'd7);
        // Branch outranks ex_busy as well, also from FLUSH
        ex_busy = 1;
        #1;
        chk("br_busy_ctl", {27'd0, ctl()}, 32'b11111);
        tick();
        chk("br2_flushes", {16'd0, flushes}, 32'd2);
        idle();
        tick();
        chk("after_br_state", {30'd0, st}, {30'd0, RUN});

        // Saturation on the 4-bit instance (starts at 7 stalls)
        ex_busy = 1;
        for (int i = 0; i < 10; i++) tick();
        chk("sat_small", {28'd0, s_stalls}, 32'hF);
        chk("wide_not_sat", {16'd0, stalls}, 32'd17);
        tick();
        chk("sat_small_hold", {28'd0, s_stalls}, 32'hF);
        // Clear wins over a stall in the same cycle; FSM unaffected
        perf_clear = 1;
        tick();
        chk("clr_stalls", {16'd0, stalls}, 32'd0);
        chk("clr_small", {28'd0, s_stalls}, 32'd0);
        chk("clr_flushes", {16'd0, flushes}, 32'd0);
        chk("clr_state", {30'd0, st}, {30'd0, EX_WAIT});
        perf_clear = 0;
        tick();
        chk("post_clr_stalls", {16'd0, stalls}, 32'd1);

        // Asynchronous reset during EX_WAIT
        #2 reset_n = 0;
        branch_taken_ex = 1;
        #1;
        chk("arst_state", {30'd0, st}, {30'd0, RUN});
        chk("arst_stalls", {16'd0, stalls}, 32'd0);
        chk("arst_ctl", {27'd0, ctl()}, 32'b00000);
        tick();
        chk("arst_held_flushes", {16'd0, flushes}, 32'd0);
        idle();
        reset_n = 1;
        #1;
        chk("rel_ctl", {27'd0, ctl()}, 32'b11100);
        tick();
        chk("rel_state", {30'd0, st}, {30'd0, RUN});
        chk("rel_stalls", {16'd0, stalls}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
